lsu_ctrl: RTL and testbench

- Load/store initiator between the core datapath and the external data memory.
- Accepts byte/half/word load and store requests from the core.
- Generates memory request, write-enable, byte-enable, address and lane-replicated write data.
- Holds the core stalled until the access completes, then returns sign- or zero-extended load data. Flags misaligned/illegal accesses and memory timeouts.

---
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Core/memory bus bundle for the load/store unit.
// The slave modport is the LSU itself; the master modport is the core plus memory environment.
interface lsu_ctrl_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, core_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, core_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: a two-state IDLE/BUSY controller that issues one memory access
// per core request, stalls the core until completion and returns extended load data.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        we_r;
    logic [2:0]  size_r;
    logic [1:0]  off_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wd_r;

    logic        legal_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;

    function automatic logic is_legal(input logic we, input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (off[0] == 1'b0);
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] rep;
        case (size[1:0])
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            2'b10:   rep = wd;
            default: rep = 32'h0000_0000;
        endcase
        return rep;
    endfunction

    // Lane is picked from the latched byte offset, then widened according to size.
    function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] ext;
        sh = word >> {off, 3'b000};
        case (size)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b010:  ext = word;
            3'b100:  ext = {24'h00_0000, sh[7:0]};
            3'b101:  ext = {16'h0000, sh[15:0]};
            default: ext = 32'h0000_0000;
        endcase
        return ext;
    endfunction

    assign legal_s = is_legal(bus.core_we_i, bus.core_size_i, bus.core_addr_i[1:0]);
    assign be_s    = lane_be(bus.core_size_i, bus.core_addr_i[1:0]);
    assign wd_s    = lane_wd(bus.core_size_i, bus.core_wd_i);

    // Output decode; the request cycle drives memory straight from the core so latency is two cycles.
    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_be_o     = 4'b0000;
        bus.mem_addr_o   = 32'h0000_0000;
        bus.mem_wd_o     = 32'h0000_0000;
        bus.core_rd_o    = 32'h0000_0000;
        bus.core_stall_o = 1'b0;
        bus.core_err_o   = 1'b0;
        if (rst_i) begin
            bus.mem_req_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.core_req_i && legal_s) begin
                        bus.mem_req_o    = 1'b1;
                        bus.mem_we_o     = bus.core_we_i;
                        bus.mem_be_o     = be_s;
                        bus.mem_addr_o   = {bus.core_addr_i[31:2], 2'b00};
                        bus.mem_wd_o     = wd_s;
                        bus.core_stall_o = 1'b1;
                    end else if (bus.core_req_i) begin
                        bus.core_err_o = 1'b1;
                    end else begin
                        bus.core_err_o = 1'b0;
                    end
                end
                BUSY: begin
                    bus.mem_req_o  = 1'b1;
                    bus.mem_we_o   = we_r;
                    bus.mem_be_o   = be_r;
                    bus.mem_addr_o = addr_r;
                    bus.mem_wd_o   = wd_r;
                    if (bus.mem_ready_i) begin
                        bus.core_rd_o = we_r ? 32'h0000_0000 : load_extend(size_r, off_r, bus.mem_rd_i);
                    end else if (cnt_r == CNT_LAST) begin
                        bus.core_err_o = 1'b1;
                    end else begin
                        bus.core_stall_o = 1'b1;
                    end
                end
                default: begin
                    bus.mem_req_o = 1'b0;
                end
            endcase
        end
    end

    // FSM state, timeout counter and the request latched at acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            we_r    <= 1'b0;
            size_r  <= 3'b000;
            off_r   <= 2'b00;
            addr_r  <= 32'h0000_0000;
            be_r    <= 4'b0000;
            wd_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.core_req_i && legal_s) begin
                        we_r    <= bus.core_we_i;
                        size_r  <= bus.core_size_i;
                        off_r   <= bus.core_addr_i[1:0];
                        addr_r  <= {bus.core_addr_i[31:2], 2'b00};
                        be_r    <= be_s;
                        wd_r    <= wd_s;
                        cnt_r   <= 8'd0;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready_i || (cnt_r == CNT_LAST)) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word memory; inputs change 1 time unit after
// the rising edge and outputs are sampled on the falling edge.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [0:63];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mem_rd_i    = mem[bus.mem_addr_o[7:2]];
    assign bus.mem_ready_i = ready;

    // Memory image is reloaded on reset; byte-enabled writes on completion.
    always @(posedge clk) begin
        if (rst) begin
            mem[4] <= 32'h8899AABB;
            mem[8] <= 32'h11223344;
        end else if (bus.mem_req_o && bus.mem_we_o && bus.mem_ready_i) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be_o[b]) mem[bus.mem_addr_o[7:2]][b*8 +: 8] <= bus.mem_wd_o[b*8 +: 8];
        end
    end

    task automatic cyc(input logic r, input logic rdy, input logic req, input logic we,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst = r; ready = rdy;
        bus.core_req_i = req; bus.core_we_i = we; bus.core_size_i = size;
        bus.core_addr_i = addr; bus.core_wd_i = wd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_size_i = 3'b000;
        bus.core_addr_i = 32'h0; bus.core_wd_i = 32'h0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.mem_req_o); end
        checks++; if (bus.mem_be_o !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b exp 0000", bus.mem_be_o); end
        checks++; if (bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h exp 0", bus.core_rd_o); end
        checks++; if (bus.core_stall_o !== 1'b0 || bus.core_err_o !== 1'b0) begin errors++; $display("FAIL reset_stall_err: got %b%b exp 00", bus.core_stall_o, bus.core_err_o); end
        checks++; if (bus.mem_addr_o !== 32'h0 || bus.mem_wd_o !== 32'h0 || bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_bus: got addr %h wd %h we %b exp 0", bus.mem_addr_o, bus.mem_wd_o, bus.mem_we_o); end
    endtask

    task automatic test_loads();
        logic [2:0]  sz  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h13, 32'h11, 32'h10, 32'h12};
        logic [3:0]  ebe [4] = '{4'b1000, 4'b0010, 4'b0011, 4'b1100};
        logic [31:0] erd [4] = '{32'hFFFFFF88, 32'h000000AA, 32'hFFFFAABB, 32'h00008899};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, sz[i], ad[i], 32'h0);
            checks++; if (bus.mem_req_o !== 1'b1 || bus.core_stall_o !== 1'b1) begin errors++; $display("FAIL load%0d_c0_req_stall: got %b%b exp 11", i, bus.mem_req_o, bus.core_stall_o); end
            checks++; if (bus.mem_be_o !== ebe[i] || bus.mem_addr_o !== 32'h10) begin errors++; $display("FAIL load%0d_c0_be_addr: got %b %h exp %b 00000010", i, bus.mem_be_o, bus.mem_addr_o, ebe[i]); end
            checks++; if (bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL load%0d_c0_rd: got %h exp 0", i, bus.core_rd_o); end
            cyc(1'b0, 1'b1, 1'b1, 1'b0, sz[i], ad[i], 32'h0);
            checks++; if (bus.core_stall_o !== 1'b0 || bus.core_rd_o !== erd[i]) begin errors++; $display("FAIL load%0d_c1: got stall %b rd %h exp 0 %h", i, bus.core_stall_o, bus.core_rd_o, erd[i]); end
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            checks++; if (bus.mem_req_o !== 1'b0 || bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL load%0d_idle: got req %b rd %h exp 0 0", i, bus.mem_req_o, bus.core_rd_o); end
        end
    endtask

    task automatic test_stores();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h21, 32'h123456C3);
        checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'b0010 || bus.mem_addr_o !== 32'h20) begin errors++; $display("FAIL sb_c0: got we %b be %b addr %h exp 1 0010 00000020", bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o); end
        checks++; if (bus.mem_wd_o !== 32'hC3C3C3C3 || bus.core_stall_o !== 1'b1) begin errors++; $display("FAIL sb_c0_wd: got %h stall %b exp c3c3c3c3 1", bus.mem_wd_o, bus.core_stall_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h21, 32'h123456C3);
        checks++; if (bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'h0 || bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL sb_c1: got stall %b rd %h we %b exp 0 0 1", bus.core_stall_o, bus.core_rd_o, bus.mem_we_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (bus.core_rd_o !== 32'h1122C344) begin errors++; $display("FAIL lw_after_sb: got %h exp 1122c344", bus.core_rd_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
        checks++; if (bus.mem_be_o !== 4'b1100 || bus.mem_wd_o !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_c0: got be %b wd %h exp 1100 beefbeef", bus.mem_be_o, bus.mem_wd_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        checks++; if (bus.core_rd_o !== 32'hBEEFC344) begin errors++; $display("FAIL lw_after_sh: got %h exp beefc344", bus.core_rd_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_illegal();
        logic        we [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  sz [3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] ad [3] = '{32'h22, 32'h11, 32'h10};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, we[i], sz[i], ad[i], 32'hFFFF_FFFF);
            checks++; if (bus.core_err_o !== 1'b1 || bus.mem_req_o !== 1'b0 || bus.core_stall_o !== 1'b0) begin errors++; $display("FAIL illegal%0d_c0: got err %b req %b stall %b exp 1 0 0", i, bus.core_err_o, bus.mem_req_o, bus.core_stall_o); end
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            checks++; if (bus.core_err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL illegal%0d_c1: got err %b req %b exp 0 0", i, bus.core_err_o, bus.mem_req_o); end
        end
        checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL illegal_no_write: got %h exp 8899aabb", mem[4]); end
    endtask

    task automatic test_wait_states();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
            checks++; if (bus.core_stall_o !== 1'b1 || bus.mem_addr_o !== 32'h10 || bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL wait_c%0d: got stall %b addr %h rd %h exp 1 00000010 0", k, bus.core_stall_o, bus.mem_addr_o, bus.core_rd_o); end
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'h8899AABB || bus.mem_addr_o !== 32'h10) begin errors++; $display("FAIL wait_done: got stall %b rd %h addr %h exp 0 8899aabb 00000010", bus.core_stall_o, bus.core_rd_o, bus.mem_addr_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
            checks++; if (bus.core_stall_o !== 1'b1 || bus.core_err_o !== 1'b0) begin errors++; $display("FAIL timeout_c%0d: got stall %b err %b exp 1 0", k, bus.core_stall_o, bus.core_err_o); end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_err_o !== 1'b1 || bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL timeout_abort: got err %b stall %b rd %h exp 1 0 0", bus.core_err_o, bus.core_stall_o, bus.core_rd_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (bus.core_err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: got err %b req %b exp 0 0", bus.core_err_o, bus.mem_req_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_stall_o !== 1'b1 || bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL timeout_next_c0: got stall %b req %b exp 1 1", bus.core_stall_o, bus.mem_req_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_rd_o !== 32'h8899AABB || bus.core_stall_o !== 1'b0) begin errors++; $display("FAIL timeout_next_c1: got rd %h stall %b exp 8899aabb 0", bus.core_rd_o, bus.core_stall_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_reset_busy();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_stall_o !== 1'b1) begin errors++; $display("FAIL rstbusy_c0: got stall %b exp 1", bus.core_stall_o); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if (bus.mem_req_o !== 1'b0 || bus.core_stall_o !== 1'b0 || bus.core_err_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL rstbusy_after: got req %b stall %b err %b addr %h exp 0 0 0 0", bus.mem_req_o, bus.core_stall_o, bus.core_err_o, bus.mem_addr_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_stall_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin errors++; $display("FAIL rstbusy_lw_c0: got stall %b addr %h exp 1 00000010", bus.core_stall_o, bus.mem_addr_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (bus.core_rd_o !== 32'h8899AABB || bus.core_stall_o !== 1'b0) begin errors++; $display("FAIL rstbusy_lw_c1: got rd %h stall %b exp 8899aabb 0", bus.core_rd_o, bus.core_stall_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_illegal();
        test_wait_states();
        test_timeout();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
